// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-file geometry,
// branch address-select encodings and the branch-resolution FSM states.
package hazard_ctrl_pkg;

    localparam int NUM_REGS = 16;
    localparam int RW       = $clog2(NUM_REGS);

    localparam logic [1:0] BR_SEL_NONE  = 2'b00;
    localparam logic [1:0] BR_SEL_TAKEN = 2'b01;
    localparam logic [1:0] BR_SEL_SEQ   = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_BR_DONE = 2'd2
    } br_state_e;

    function automatic logic [1:0] br_sel(input logic taken);
        return taken ? BR_SEL_TAKEN : BR_SEL_SEQ;
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register pending-write counters with combinational dependency lookup.
// Lookups see pre-update counts, so a same-cycle retirement does not release a stall.
module hz_scoreboard #(
    parameter int  NUM_REGS = 16,
    parameter int  CNT_W    = 2,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [RW-1:0] src1,
    input  logic          src1_vld,
    input  logic [RW-1:0] src2,
    input  logic          src2_vld,
    input  logic [RW-1:0] dest,
    input  logic          dest_vld,
    input  logic          inc,
    input  logic          dec,
    input  logic [RW-1:0] dec_reg,
    output logic          dep_hit,
    output logic          underflow
);
    import hazard_ctrl_pkg::*;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                // issue and retire on the same register cancel out
                if (inc && dest == RW'(r) && !(dec && dec_reg == RW'(r)))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec && dec_reg == RW'(r) && !(inc && dest == RW'(r)) && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    assign dep_hit = (src1_vld && cnt[src1] != '0) ||
                     (src2_vld && cnt[src2] != '0) ||
                     (dest_vld && cnt[dest] == '1);

    assign underflow = dec && cnt[dec_reg] == '0 && !(inc && dest == dec_reg);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: dependency stalls from the scoreboard plus the
// branch-resolution FSM that drives fetch stall and redirect select.
module hazard_ctrl #(
    parameter int  NUM_REGS = hazard_ctrl_pkg::NUM_REGS,
    parameter int  CNT_W    = 2,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic          I_CLOCK,
    input  logic          I_RESET_N,
    input  logic          I_LOCK,
    input  logic          I_DE_Valid,
    input  logic          I_DE_IsBranch,
    input  logic [RW-1:0] I_DE_Src1,
    input  logic [RW-1:0] I_DE_Src2,
    input  logic          I_DE_Src1Vld,
    input  logic          I_DE_Src2Vld,
    input  logic [RW-1:0] I_DE_Dest,
    input  logic          I_DE_DestVld,
    input  logic          I_MEM_BrResolved,
    input  logic          I_MEM_BrTaken,
    input  logic          I_WB_Valid,
    input  logic [RW-1:0] I_WB_Dest,
    output logic          O_DepStall,
    output logic          O_BranchStall,
    output logic [1:0]    O_BranchAddrSelect,
    output logic          O_Issue,
    output logic          O_HazErr
);
    import hazard_ctrl_pkg::*;

    br_state_e  state, state_nxt;
    logic [1:0] sel, sel_nxt;
    logic       err, err_nxt;
    logic       dep_hit, underflow, run, br_issue;

    hz_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk       (I_CLOCK),
        .rst_n     (I_RESET_N),
        .clr       (~I_LOCK),
        .src1      (I_DE_Src1),
        .src1_vld  (I_DE_Src1Vld),
        .src2      (I_DE_Src2),
        .src2_vld  (I_DE_Src2Vld),
        .dest      (I_DE_Dest),
        .dest_vld  (I_DE_DestVld),
        .inc       (O_Issue & I_DE_DestVld),
        .dec       (I_WB_Valid),
        .dec_reg   (I_WB_Dest),
        .dep_hit   (dep_hit),
        .underflow (underflow)
    );

    // Outside RUN the branch stall dominates, so dependency stall is masked.
    assign run                = (state == ST_RUN);
    assign O_DepStall         = I_DE_Valid & run & dep_hit;
    assign O_Issue            = I_DE_Valid & I_LOCK & ~O_DepStall & run;
    assign br_issue           = O_Issue & I_DE_IsBranch;
    assign O_BranchStall      = br_issue | (state == ST_BR_WAIT);
    assign O_BranchAddrSelect = sel;
    assign O_HazErr           = err;

    always_comb begin
        state_nxt = state;
        sel_nxt   = BR_SEL_NONE;
        err_nxt   = err | underflow | (I_MEM_BrResolved & (state != ST_BR_WAIT));
        case (state)
            ST_RUN: begin
                if (br_issue) state_nxt = ST_BR_WAIT;
            end
            ST_BR_WAIT: begin
                if (I_MEM_BrResolved) begin
                    state_nxt = ST_BR_DONE;
                    sel_nxt   = br_sel(I_MEM_BrTaken);
                end
            end
            ST_BR_DONE: state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state <= ST_RUN;
            sel   <= BR_SEL_NONE;
            err   <= 1'b0;
        end else if (!I_LOCK) begin
            state <= ST_RUN;
            sel   <= BR_SEL_NONE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            err   <= err_nxt;
        end
    end

endmodule
